dmem_arbiter: RTL

Two-requester arbiter and sequencer for the single-port data memory of the single-cycle CPU. Shares the memory between the CPU load/store path (requester 0) and the debug/dump engine (requester 1), which reads and writes memory for bench and board inspection. Each access is sequenced through a fixed 3-state handshake. The CPU is stalled while its access is pending. A starvation guard keeps the debug port from being locked out.

---
 rtl/dmem_arbiter_if.sv | 22 ++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Requester-side bus of the data-memory arbiter. One instance
//                per requester (CPU load/store path, debug/dump engine).
//                master = requester, slave = arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int ADDR_W = 11
);
  logic              req;
  logic              wena;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;

  modport master (output req, wena, addr, wdata, input rdata, ack);
  modport slave  (input req, wena, addr, wdata, output rdata, ack);
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-requester arbiter/sequencer for the single-port data
//                memory. Every access walks IDLE -> ISSUE -> DONE. The CPU has
//                priority; defining DMEM_ARB_STARVE_EN adds a starvation guard
//                that forces the debug port through after STARVE_LIMIT lost
//                arbitrations in a row.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W       = 11,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  wire               clk_in,
  input  wire               reset,
  dmem_arbiter_if.slave     cpu,
  dmem_arbiter_if.slave     dbg,
  output logic              cpu_stall,
  output logic              dm_ena,
  output logic              dm_wena,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_data_in,
  input  wire  [31:0]       dm_data_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // The starvation counter must be able to reach STARVE_LIMIT.
  if (STARVE_LIMIT >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("dmem_arbiter: CNT_W too narrow for STARVE_LIMIT");
  end

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              any_req;
  logic              grant_dbg;
  logic              owner_dbg;
  logic              lat_wena;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       cpu_rdata_q;
  logic [31:0]       dbg_rdata_q;

  assign any_req = cpu.req | dbg.req;

`ifdef DMEM_ARB_STARVE_EN
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_guard;

  assign starve_guard = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_dbg    = dbg.req & (~cpu.req | starve_guard);

  // Count consecutive CPU wins over a waiting debug port; saturate at the limit.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!dbg.req || grant_dbg) begin
        starve_cnt <= '0;
      end else if (cpu.req && !starve_guard) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`else
  // Strict CPU priority: the debug port only wins when the CPU is quiet.
  assign grant_dbg = dbg.req & ~cpu.req;
`endif

  // State register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; requests are only sampled in IDLE, so a req left high
  // during DONE cannot be regranted.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = any_req ? ISSUE : IDLE;
      ISSUE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner and its operands at the granting IDLE edge.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      owner_dbg <= 1'b0;
      lat_wena  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      owner_dbg <= grant_dbg;
      lat_wena  <= grant_dbg ? dbg.wena  : cpu.wena;
      lat_addr  <= grant_dbg ? dbg.addr  : cpu.addr;
      lat_wdata <= grant_dbg ? dbg.wdata : cpu.wdata;
    end
  end

  // Hold each owner's read data after its DONE cycle until its next access.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else if (state == DONE) begin
      if (owner_dbg) begin
        dbg_rdata_q <= dm_data_out;
      end else begin
        cpu_rdata_q <= dm_data_out;
      end
    end
  end

  // Outputs decoded from state; memory is driven only in ISSUE, acks only in
  // DONE. During DONE the memory output is passed straight through so rdata
  // is already valid while ack is high.
  always_comb begin
    dm_ena     = (state == ISSUE);
    dm_wena    = (state == ISSUE) & lat_wena;
    dm_addr    = (state == ISSUE) ? lat_addr  : '0;
    dm_data_in = (state == ISSUE) ? lat_wdata : '0;
    cpu.ack    = (state == DONE) & ~owner_dbg;
    dbg.ack    = (state == DONE) &  owner_dbg;
    cpu.rdata  = cpu.ack ? dm_data_out : cpu_rdata_q;
    dbg.rdata  = dbg.ack ? dm_data_out : dbg_rdata_q;
    cpu_stall  = cpu.req & ~cpu.ack;
  end

endmodule
`default_nettype wire
